// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for the HI/LO path (DIV / DIVU).
// result = {remainder, quotient}; ready and result are registered outputs.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        BUSY,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, state_next;
    logic [CW-1:0]      count, count_next;
    logic [2*WIDTH:0]   work, work_next;
    logic [WIDTH-1:0]   divisor, divisor_next;
    logic               quo_neg, quo_neg_next;
    logic               rem_neg, rem_neg_next;
    logic [2*WIDTH-1:0] result_next;
    logic               ready_next;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand magnitudes; |0x80000000| stays 0x80000000 as an unsigned value.
    assign mag1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign mag2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    assign shifted = {work[2*WIDTH-1:0], 1'b0};
    assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};

    assign quo_fix = quo_neg ? -work[WIDTH-1:0]       : work[WIDTH-1:0];
    assign rem_fix = rem_neg ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next   = state;
        count_next   = count;
        work_next    = work;
        divisor_next = divisor;
        quo_neg_next = quo_neg;
        rem_neg_next = rem_neg;
        result_next  = result;
        ready_next   = ready;

        case (state)
            IDLE: begin
                if (start && !annul) begin
                    divisor_next = mag2;
                    work_next    = {{(WIDTH+1){1'b0}}, mag1};
                    quo_neg_next = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    rem_neg_next = signed_div & opdata1[WIDTH-1];
                    count_next   = '0;
                    state_next   = (opdata2 == '0) ? BYZERO : BUSY;
                end
            end
            BYZERO: begin
                if (annul) begin
                    state_next = IDLE;
                end else begin
                    // Zero divisor reuses the completion step with a zero working register,
                    // so the result is forced to 0 and ready rises one edge later.
                    work_next    = '0;
                    quo_neg_next = 1'b0;
                    rem_neg_next = 1'b0;
                    count_next   = CW'(WIDTH);
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (annul) begin
                    state_next  = IDLE;
                    result_next = '0;
                    ready_next  = 1'b0;
                end else if (count == CW'(WIDTH)) begin
                    result_next = {rem_fix, quo_fix};
                    ready_next  = 1'b1;
                    state_next  = DONE;
                end else begin
                    // Non-negative trial difference keeps it and shifts in a quotient 1.
                    work_next  = diff[WIDTH] ? shifted : {diff, shifted[WIDTH-1:1], 1'b1};
                    count_next = count + CW'(1);
                end
            end
            DONE: begin
                if (annul || !start) begin
                    state_next  = IDLE;
                    result_next = '0;
                    ready_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            work    <= '0;
            divisor <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            work    <= work_next;
            divisor <= divisor_next;
            quo_neg <= quo_neg_next;
            rem_neg <= rem_neg_next;
            result  <= result_next;
            ready   <= ready_next;
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed cases from the divider's rules plus
// random operands checked against an arithmetic reference model.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_radix2 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    // Reference: plain integer division, truncating toward zero; x/0 yields 0.
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (!sd) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // One full divide: latency, result, hold while start stays high, clear on start drop.
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string name);
        int lat;
        int exp_lat;
        exp_lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        signed_div = sd; opdata1 = a; opdata2 = b; start = 1'b1; annul = 1'b0;
        lat = -1;
        for (int i = 0; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
            end
            if (ready === 1'b1) lat = i;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (result !== exp) begin
            n_err++; $display("FAIL %s result: got %h expected %h", name, result, exp);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1 || result !== exp) begin
            n_err++; $display("FAIL %s hold: got ready=%b result=%h expected ready=1 result=%h", name, ready, result, exp);
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL %s clear: got ready=%b result=%h expected ready=0 result=0", name, ready, result);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL reset: got ready=%b result=%h expected 0/0", ready, result);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL post_reset_idle: got ready=%b result=%h expected 0/0", ready, result);
        end
    endtask

    task automatic test_directed();
        run_div(1'b0, 32'd100,       32'd7,          64'h00000002_0000000E, "u100_7");
        run_div(1'b1, 32'hFFFFFFF9,  32'h00000002,   64'hFFFFFFFF_FFFFFFFD, "s-7_2");
        run_div(1'b1, 32'd7,         32'hFFFFFFFE,   64'h00000001_FFFFFFFD, "s7_-2");
        run_div(1'b0, 32'd5,         32'd0,          64'd0,                 "div_zero");
        run_div(1'b1, 32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, "s_overflow");
        run_div(1'b0, 32'hFFFFFFFF,  32'd1,          64'h00000000_FFFFFFFF, "u_max_1");
    endtask

    task automatic test_annul();
        int seen;
        // Annul mid-BUSY, then a fresh divide.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk); annul = 1'b1; start = 1'b0;
        @(negedge clk); annul = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready !== 1'b0 || result !== 64'd0) seen++; end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL annul_busy: got %0d cycles with output set expected 0", seen);
        end
        run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after_annul");

        // Annul with start in IDLE suppresses the request.
        @(negedge clk);
        opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b0; annul = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready !== 1'b0) seen++; end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL annul_idle: got %0d ready cycles expected 0", seen);
        end

        // Annul in BYZERO.
        @(negedge clk);
        opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        @(negedge clk); annul = 1'b1; start = 1'b0;
        @(negedge clk); annul = 1'b0;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (ready !== 1'b0) seen++; end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL annul_byzero: got %0d ready cycles expected 0", seen);
        end

        // Annul in DONE with start still high clears the outputs.
        @(negedge clk);
        opdata1 = 32'd77; opdata2 = 32'd0; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL annul_done: got ready=%b result=%h expected 0/0", ready, result);
        end
        @(negedge clk); annul = 1'b0; start = 1'b0;
    endtask

    task automatic test_async_reset();
        int seen;
        int lat;
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1234; opdata2 = 32'd10; start = 1'b1; annul = 1'b0;
        repeat (16) @(posedge clk);
        #3 rst = 1'b1; start = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL rst_busy: got ready=%b result=%h expected 0/0", ready, result);
        end
        #2 rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready !== 1'b0) seen++; end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL rst_abort: got %0d ready cycles expected 0", seen);
        end

        // Reset between edges while a result is being held.
        @(negedge clk);
        opdata1 = 32'd1234; opdata2 = 32'd10; start = 1'b1;
        lat = -1;
        for (int i = 0; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) lat = i;
        end
        n_cmp++;
        if (lat !== 33 || result !== {32'd4, 32'd123}) begin
            n_err++; $display("FAIL rst_pre_done: got lat=%0d result=%h expected 33 %h", lat, result, {32'd4, 32'd123});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL rst_done: got ready=%b result=%h expected 0/0", ready, result);
        end
        start = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic test_random();
        logic        sd;
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            sd = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       begin b = $urandom; a = 32'h80000000; end
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(1, 28);
            run_div(sd, a, b, ref_div(sd, a, b), "random");
        end
    endtask

    task automatic test_back_to_back();
        // run_div drops start, then the next call raises it one IDLE cycle later.
        run_div(1'b1, 32'hFFFFFF9C, 32'd9,       ref_div(1'b1, 32'hFFFFFF9C, 32'd9),       "b2b_0");
        run_div(1'b0, 32'hDEADBEEF, 32'h1234,    ref_div(1'b0, 32'hDEADBEEF, 32'h1234),    "b2b_1");
        run_div(1'b1, 32'h7FFFFFFF, 32'h80000000, ref_div(1'b1, 32'h7FFFFFFF, 32'h80000000), "b2b_2");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_annul();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
